// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 width codes and FSM state type shared by the memory-stage LSU
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane formatting, load extraction/extension and access classification
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [2:0]      funct3,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned,
   output logic            illegal
);
   logic [1:0]  size;
   logic        sx;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   // Lane replication/strobes for stores, shifted and extended data for loads
   always_comb begin
      size = funct3[1:0];
      sx = ~funct3[2];
      byte_v = 8'(rdata >> {addr, 3'b000});
      half_v = 16'(rdata >> {addr[1], 4'b0000});
      load_data = size == F3_B[1:0] ? {{(XLEN-8){sx & byte_v[7]}}, byte_v}
                : size == F3_H[1:0] ? {{(XLEN-16){sx & half_v[15]}}, half_v} : rdata;
      wdata = size == F3_B[1:0] ? {(XLEN/8){store_data[7:0]}}
            : size == F3_H[1:0] ? {(XLEN/16){store_data[15:0]}} : store_data;
      wstrb = !we ? 4'b0000 : size == F3_B[1:0] ? 4'b0001 << addr
            : size == F3_H[1:0] ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
      misaligned = (size == F3_H[1:0] & addr[0]) | (size == F3_W[1:0] & addr != 2'b00);
      illegal = size == 2'b11 | (funct3[2] & (we | funct3[1]));
   end
endmodule

// File: rtl/stage_lsu.sv
// stage_lsu: memory-stage load/store unit driving a single-outstanding req/gnt/rvalid bus
module stage_lsu
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            execute_mem_valid,
   input  logic            execute_mem_write,
   input  logic [2:0]      execute_funct3,
   input  logic [XLEN-1:0] execute_alu_result,
   input  logic [XLEN-1:0] execute_store_data,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_wstrb,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata,
   output logic [XLEN-1:0] mem_read_data,
   output logic            mem_load_valid,
   output logic            lsu_stall,
   output logic            lsu_misaligned,
   output logic            lsu_bus_error
);
   localparam int CW = $clog2(TIMEOUT + 1);
   lsu_state_t      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [2:0]      f3_q, f3_d;
   logic            we_q, we_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            load_valid_q, load_valid_d, mis_q, mis_d, err_q, err_d;
   logic            idle, accept, done, timeout;
   logic [3:0]      a_wstrb;
   logic [XLEN-1:0] a_wdata, a_load;
   logic            a_mis, a_ill;

   assign idle    = state_q == IDLE;
   assign accept  = idle & execute_mem_valid & ~a_ill & ~a_mis;
   assign done    = (state_q == REQ & bus_gnt & bus_rvalid) | (state_q == RESP & bus_rvalid);
   assign timeout = ~idle & ~done & cnt_q == CW'(TIMEOUT);

   // Idle: classify/format the incoming op; busy: extract the captured load from bus_rdata
   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (idle ? execute_funct3 : f3_q),
      .we         (idle ? execute_mem_write : we_q),
      .addr       (idle ? execute_alu_result[1:0] : addr_q[1:0]),
      .store_data (execute_store_data),
      .rdata      (bus_rdata),
      .wstrb      (a_wstrb),
      .wdata      (a_wdata),
      .load_data  (a_load),
      .misaligned (a_mis),
      .illegal    (a_ill)
   );

   // Next state, payload capture, timeout count and one-cycle status pulses
   always_comb begin
      state_d = accept ? REQ : (done | timeout) ? IDLE : (state_q == REQ & bus_gnt) ? RESP : state_q;
      cnt_d = accept ? '0 : idle ? cnt_q : cnt_q + 1'b1;
      addr_d = accept ? execute_alu_result : addr_q;
      f3_d = accept ? execute_funct3 : f3_q;
      we_d = accept ? execute_mem_write : we_q;
      wdata_d = accept ? a_wdata : wdata_q;
      wstrb_d = accept ? a_wstrb : wstrb_q;
      rdata_d = timeout ? '0 : (done & ~we_q) ? a_load : rdata_q;
      load_valid_d = done & ~we_q;
      mis_d = idle & execute_mem_valid & ~a_ill & a_mis;
      err_d = timeout;
   end

   // State and output registers, cleared by synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         f3_q         <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rdata_q      <= '0;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         f3_q         <= f3_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rdata_q      <= rdata_d;
         load_valid_q <= load_valid_d;
         mis_q        <= mis_d;
         err_q        <= err_d;
      end
   end

   assign bus_req        = state_q == REQ;
   assign bus_we         = we_q;
   assign bus_addr       = {addr_q[XLEN-1:2], 2'b00};
   assign bus_wdata      = wdata_q;
   assign bus_wstrb      = wstrb_q;
   assign mem_read_data  = rdata_q;
   assign mem_load_valid = load_valid_q;
   assign lsu_stall      = accept | (~idle & ~done & ~timeout);
   assign lsu_misaligned = mis_q;
   assign lsu_bus_error  = err_q;
endmodule

// File: tb/tb_stage_lsu.sv
// tb_stage_lsu: directed and randomized checks of stage_lsu against a transaction-level model
module tb_stage_lsu;
   localparam int TIMEOUT = 255;
   logic        clk = 1'b0;
   logic        rst, v, w, g, rv;
   logic [2:0]  f3;
   logic [31:0] addr, sd, rd;
   logic        bus_req, bus_we, mem_load_valid, lsu_stall, lsu_misaligned, lsu_bus_error;
   logic [31:0] bus_addr, bus_wdata, mem_read_data;
   logic [3:0]  bus_wstrb;
   int          n_chk = 0, n_pass = 0;
   bit          m_busy, m_gnt, m_w, m_lv, m_mis, m_err;
   int          m_cyc, m_f3;
   logic [31:0] m_addr, m_sd, m_rd;
   logic        o_req, o_we, o_stall, o_lv, o_mis, o_err;
   logic [31:0] o_addr, o_wdata, o_rd;
   logic [3:0]  o_wstrb;

   always #5 clk = ~clk;

   stage_lsu #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .execute_mem_valid(v), .execute_mem_write(w), .execute_funct3(f3),
      .execute_alu_result(addr), .execute_store_data(sd),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_gnt(g), .bus_rvalid(rv), .bus_rdata(rd),
      .mem_read_data(mem_read_data), .mem_load_valid(mem_load_valid), .lsu_stall(lsu_stall),
      .lsu_misaligned(lsu_misaligned), .lsu_bus_error(lsu_bus_error)
   );

   function automatic bit legal(bit wr, int f);
      return wr ? (f inside {0, 1, 2}) : (f inside {0, 1, 2, 4, 5});
   endfunction

   function automatic int nbytes(int f);
      return 1 << (f % 4);
   endfunction

   function automatic logic [31:0] st_data(int f, logic [31:0] d);
      if (nbytes(f) == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (nbytes(f) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [3:0] st_strb(int f, logic [31:0] a);
      logic [3:0] m;
      m = 4'((1 << nbytes(f)) - 1);
      return m << (a % 4);
   endfunction

   function automatic logic [31:0] ld_data(int f, logic [31:0] a, logic [31:0] r);
      int n;
      logic [31:0] mask, val;
      n = nbytes(f);
      if (n == 4) return r;
      mask = (32'd1 << (8 * n)) - 1;
      val = (r >> (8 * (a % 4))) & mask;
      if (f < 4 && val[8 * n - 1]) val = val | ~mask;
      return val;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_in(input bit iv, iw, input int if3, input logic [31:0] ia, isd,
                         input bit ig, irv, input logic [31:0] ird);
      v = iv; w = iw; f3 = 3'(if3); addr = ia; sd = isd; g = ig; rv = irv; rd = ird;
   endtask

   task automatic idle_in();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      m_busy = 0; m_gnt = 0; m_cyc = 0; m_lv = 0; m_mis = 0; m_err = 0; m_rd = 0;
   endtask

   // One cycle: compare DUT against the model away from the edge, then advance the model
   task automatic step();
      bit done, to, acc, aligned;
      #1;
      o_req = bus_req; o_we = bus_we; o_stall = lsu_stall; o_lv = mem_load_valid;
      o_mis = lsu_misaligned; o_err = lsu_bus_error; o_addr = bus_addr;
      o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_rd = mem_read_data;
      done = m_busy && ((!m_gnt && g && rv) || (m_gnt && rv));
      to = m_busy && !done && m_cyc == TIMEOUT;
      aligned = (addr % nbytes(f3)) == 0;
      acc = !m_busy && v && legal(w, f3) && aligned;
      chk("bus_req", o_req, m_busy && !m_gnt);
      chk("lsu_stall", o_stall, m_busy ? (!done && !to) : acc);
      chk("mem_load_valid", o_lv, m_lv);
      chk("lsu_misaligned", o_mis, m_mis);
      chk("lsu_bus_error", o_err, m_err);
      chk("mem_read_data", o_rd, m_rd);
      if (m_busy && !m_gnt) begin
         chk("bus_addr", o_addr, m_addr & ~32'h3);
         chk("bus_we", o_we, m_w);
         chk("bus_wstrb", o_wstrb, m_w ? st_strb(m_f3, m_addr) : 4'h0);
         if (m_w) chk("bus_wdata", o_wdata, st_data(m_f3, m_sd));
      end
      if (!rst) model_reset();
      else begin
         m_lv = done && !m_w;
         m_err = to;
         m_mis = !m_busy && v && legal(w, f3) && !aligned;
         if (to) m_rd = 0;
         else if (m_lv) m_rd = ld_data(m_f3, m_addr, rd);
         if (acc) begin
            m_busy = 1; m_gnt = 0; m_cyc = 0;
            m_w = w; m_f3 = f3; m_addr = addr; m_sd = sd;
         end else if (m_busy) begin
            if (done || to) m_busy = 0;
            else begin
               if (!m_gnt && g) m_gnt = 1;
               m_cyc++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int occ, stalls;
      bit seen;
      rst = 0;
      idle_in();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_bus_wstrb", bus_wstrb, 0);
      chk("rst_read_data", mem_read_data, 0);
      chk("rst_load_valid", mem_load_valid, 0);
      chk("rst_stall", lsu_stall, 0);
      chk("rst_misaligned", lsu_misaligned, 0);
      chk("rst_bus_error", lsu_bus_error, 0);
      rst = 1;
      // SW 0x100
      set_in(1, 1, 2, 32'h100, 32'hDEADBEEF, 0, 0, 0); step(); occ = o_stall;
      set_in(0, 0, 0, 0, 0, 1, 0, 0); step(); occ += o_stall;
      chk("sw_req", o_req, 1);
      chk("sw_addr", o_addr, 32'h100);
      chk("sw_wstrb", o_wstrb, 4'hF);
      chk("sw_wdata", o_wdata, 32'hDEADBEEF);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); step(); occ += o_stall;
      chk("sw_done_stall", o_stall, 0);
      chk("sw_occupancy", occ + 1, 3);
      idle_in(); step();
      chk("sw_no_load", o_lv, 0);
      // LB / LBU 0x203
      set_in(1, 0, 0, 32'h203, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 1, 1, 32'h80FF_0011); step();
      idle_in(); step();
      chk("lb_valid", o_lv, 1);
      chk("lb_data", o_rd, 32'hFFFF_FF80);
      step();
      chk("lb_pulse", o_lv, 0);
      set_in(1, 0, 4, 32'h203, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 1, 1, 32'h80FF_0011); step();
      idle_in(); step();
      chk("lbu_valid", o_lv, 1);
      chk("lbu_data", o_rd, 32'h0000_0080);
      step();
      chk("lbu_pulse", o_lv, 0);
      // SH 0x42
      set_in(1, 1, 1, 32'h42, 32'h1234_ABCD, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 1, 0, 0); step();
      chk("sh_addr", o_addr, 32'h40);
      chk("sh_wstrb", o_wstrb, 4'hC);
      chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); step();
      idle_in(); step();
      // LW misaligned 0x101
      set_in(1, 0, 2, 32'h101, 0, 0, 0, 0); step();
      chk("mis_stall", o_stall, 0);
      chk("mis_req", o_req, 0);
      idle_in(); step();
      chk("mis_pulse", o_mis, 1);
      chk("mis_req2", o_req, 0);
      step();
      chk("mis_once", o_mis, 0);
      // LW with gnt held low until timeout
      set_in(1, 0, 2, 32'h300, 0, 0, 0, 0); step();
      idle_in();
      stalls = 0;
      seen = 0;
      for (int i = 0; i < TIMEOUT + 10 && !seen; i++) begin
         step();
         if (o_err) seen = 1;
         else stalls += o_stall;
      end
      chk("to_seen", seen, 1);
      chk("to_stall_cycles", stalls, TIMEOUT);
      chk("to_rdata", o_rd, 0);
      chk("to_req", o_req, 0);
      chk("to_stall", o_stall, 0);
      step();
      chk("to_once", o_err, 0);
      // reset while waiting in RESP, then a late rvalid
      set_in(1, 0, 2, 32'h10, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 1, 0, 0); step();
      idle_in(); rst = 0; step();
      rst = 1; set_in(0, 0, 0, 0, 0, 0, 1, 32'h55); step();
      chk("rst_late_req", o_req, 0);
      chk("rst_late_stall", o_stall, 0);
      idle_in(); step();
      chk("rst_late_load", o_lv, 0);
      chk("rst_late_rdata", o_rd, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(0, 299) != 0;
         v = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if (w && f3 == 3'd3) f3 = 3'd2;
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
         sd = $urandom;
         g = 1'($urandom_range(0, 1));
         rv = $urandom_range(0, 9) < 4;
         rd = $urandom;
         step();
      end
      rst = 1;
      idle_in();
      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/stage_lsu.md
Name: stage_lsu

Overview:
- Load/store unit for the memory stage of the 5-stage RV32I pipeline.
- Takes the effective address and store data from execute and runs a single outstanding transaction on a req/gnt/rvalid data bus.
- Returns aligned, sign/zero-extended load data toward writeback.
- Stalls the upstream stages while a transaction is in flight.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 255, max cycles in REQ+RESP before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-low reset
- execute_mem_valid  in  1  EX/MEM holds a load or store
- execute_mem_write  in  1  1 = store, 0 = load
- execute_funct3  in  3  width/sign code: LB/LH/LW/LBU/LHU, SB/SH/SW
- execute_alu_result  in  XLEN  effective byte address
- execute_store_data  in  XLEN  rs2 value
- bus_req  out  1  request valid
- bus_we  out  1  write enable
- bus_addr  out  XLEN  word address, bits[1:0] forced 0
- bus_wdata  out  XLEN  lane-replicated store data
- bus_wstrb  out  4  byte enables, 0 for loads
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack
- bus_rdata  in  XLEN  read data
- mem_read_data  out  XLEN  extended load result (registered)
- mem_load_valid  out  1  1-cycle pulse, load data valid
- lsu_stall  out  1  hold fetch/decode/execute
- lsu_misaligned  out  1  1-cycle pulse, misaligned access
- lsu_bus_error  out  1  1-cycle pulse, timeout abort

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE, timeout counter 0.
  - All outputs 0.
  - Reset mid-transaction drops the request next edge; a late rvalid is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - On execute_mem_valid with a legal, aligned op: capture addr, funct3, we, wdata, wstrb; go to REQ.
  - lsu_stall is combinationally 1 in that same cycle.
  - Illegal funct3 (loads 011/110/111, stores 1xx) is a no-op: no bus activity, no flags.
  - Misaligned op (H with addr[0]=1; W with addr[1:0]!=0): lsu_misaligned pulses next cycle, no bus request, no stall, stay IDLE.
- REQ:
  - bus_req=1; payload held stable until bus_gnt.
  - On gnt go to RESP.
  - gnt and rvalid in the same cycle completes directly (goes to IDLE).
- RESP:
  - bus_req=0; wait for bus_rvalid, which is also the store ack.
  - On rvalid go to IDLE.
  - For a load, register the extracted data into mem_read_data and pulse mem_load_valid the next cycle.
- lsu_stall = (IDLE & legal aligned valid) | (state != IDLE & !completing). It deasserts in the completion cycle, so execute advances on that edge.
- Minimum latency with gnt and rvalid both 1 in REQ: 2 stall cycles.
- Store formatting:
  - SB: wstrb = 0001<<addr[1:0], wdata = byte×4.
  - SH: wstrb = 0011<<(2·addr[1]), wdata = half×2.
  - SW: wstrb = 1111.
- Load extraction:
  - LB/LBU: byte = rdata>>(8·addr[1:0]).
  - LH/LHU: half = rdata>>(16·addr[1]).
  - Sign- or zero-extend per funct3.
- Timeout:
  - Counter increments each cycle in REQ/RESP and clears on entering REQ.
  - On reaching TIMEOUT: pulse lsu_bus_error, clear mem_read_data to 0, go to IDLE, release stall.
- Back-to-back ops: a new valid in the cycle after completion is accepted (1 IDLE cycle minimum).

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state enum lsu_state_t {IDLE, REQ, RESP}
- Combinational sub-module lsu_align:
  - inputs funct3, addr[1:0], store data, rdata
  - outputs wstrb, wdata, extended load data, misaligned, illegal
- stage_lsu holds the FSM, capture registers and timeout counter.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt immediate, rvalid next cycle → bus_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, stall 3 cycles, no load pulse.
- LB addr 0x203, rdata 0x80FF_0011 → mem_read_data 0xFFFF_FF80; same with LBU → 0x0000_0080; mem_load_valid one cycle each.
- SH addr 0x42, data 0x1234_ABCD → wstrb 1100, wdata 0xABCD_ABCD, bus_addr 0x40.
- LW addr 0x101 → lsu_misaligned pulse, bus_req never 1, lsu_stall 0.
- LW with gnt held low for TIMEOUT cycles → lsu_bus_error pulse, mem_read_data 0, FSM to IDLE, stall released.
- Reset low while in RESP, then rvalid after reset → bus_req 0, no mem_load_valid, FSM IDLE.
